pipe_stage_reg: RTL and testbench

//  Generic inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) carrying a valid
//  bit, control bundle, data bundle and destination-register index. Adds valid/ready

---
 rtl/pipe_stage_reg_pkg.sv | 15 +
 rtl/pipe_stage_reg_slot.sv | 36 +++
 rtl/pipe_stage_reg.sv | 145 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared widths and the main-entry load-source encoding used by the
// inter-stage pipeline register and its slot sub-module.
package pipe_stage_reg_pkg;

  localparam int WORD_W     = 16;
  localparam int REG_W_DEF  = 3;
  localparam int CTRL_W_DEF = 3;

  typedef enum logic [1:0] {
    SRC_HOLD  = 2'd0,
    SRC_INPUT = 2'd1,
    SRC_SKID  = 2'd2
  } main_src_e;

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One pipeline entry: a valid flop plus a payload register with load and
// clear enables. Load wins over clear; clear leaves the payload untouched.
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  logic         valid_r;
  logic [W-1:0] q_r;

  // Entry state: valid bit and payload, payload moves only on load
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      q_r     <= {W{1'b0}};
    end else if (load) begin
      valid_r <= 1'b1;
      q_r     <= d;
    end else if (clr) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign valid = valid_r;
  assign q     = q_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready backpressure, flush-to-bubble,
// an optional skid entry and a saturating stall counter.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W = 4 * WORD_W,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int REG_W  = REG_W_DEF,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [REG_W-1:0]  in_wreg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [REG_W-1:0]  out_wreg,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int PAY_W = CTRL_W + DATA_W + REG_W;

  logic             main_valid_s;
  logic             skid_valid_s;
  logic [PAY_W-1:0] main_pay_s;
  logic [PAY_W-1:0] skid_pay_s;
  logic [PAY_W-1:0] in_pay_s;
  logic [PAY_W-1:0] main_d_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             drain_s;
  logic             main_open_s;
  logic             main_load_s;
  logic             main_clr_s;
  logic             skid_load_s;
  logic             skid_clr_s;
  main_src_e        main_src_s;
  logic [CNT_W-1:0] stall_cnt_r;

  assign in_pay_s    = {in_ctrl, in_data, in_wreg};
  assign accept_s    = in_valid && in_ready_s && !flush;
  assign drain_s     = main_valid_s && out_ready;
  assign main_open_s = !main_valid_s || out_ready;

  // Decide where the main entry loads from and which entries clear
  always_comb begin
    main_src_s  = SRC_HOLD;
    main_clr_s  = 1'b0;
    skid_load_s = 1'b0;
    skid_clr_s  = 1'b0;
    if (flush) begin
      main_clr_s = 1'b1;
      skid_clr_s = 1'b1;
    end else if (main_open_s) begin
      if (skid_valid_s) begin
        main_src_s = SRC_SKID;
        skid_clr_s = 1'b1;
      end else if (accept_s) begin
        main_src_s = SRC_INPUT;
      end else begin
        main_clr_s = drain_s;
      end
    end else begin
      skid_load_s = accept_s;
    end
  end

  // Translate the load source into slot enable and payload
  always_comb begin
    main_load_s = 1'b0;
    main_d_s    = main_pay_s;
    case (main_src_s)
      SRC_INPUT: begin
        main_load_s = 1'b1;
        main_d_s    = in_pay_s;
      end
      SRC_SKID: begin
        main_load_s = 1'b1;
        main_d_s    = skid_pay_s;
      end
      default: begin
        main_load_s = 1'b0;
        main_d_s    = main_pay_s;
      end
    endcase
  end

  pipe_slot #(.W(PAY_W)) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (main_load_s),
    .clr   (main_clr_s),
    .d     (main_d_s),
    .valid (main_valid_s),
    .q     (main_pay_s)
  );

  // The skid variant keeps in_ready free of any combinational path from out_ready
  generate
    if (SKID != 0) begin : g_skid
      pipe_slot #(.W(PAY_W)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load_s),
        .clr   (skid_clr_s),
        .d     (in_pay_s),
        .valid (skid_valid_s),
        .q     (skid_pay_s)
      );
      assign in_ready_s = !rst && !skid_valid_s;
    end else begin : g_noskid
      logic unused_skid_s;
      assign skid_valid_s  = 1'b0;
      assign skid_pay_s    = {PAY_W{1'b0}};
      assign unused_skid_s = ^{skid_load_s, skid_clr_s};
      assign in_ready_s    = !rst && (!main_valid_s || out_ready);
    end
  endgenerate

  // Stall counter: cleared only by rst, sticks at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (main_valid_s && !out_ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = main_valid_s;
  assign out_ctrl  = main_valid_s ? main_pay_s[PAY_W-1 -: CTRL_W] : {CTRL_W{1'b0}};
  assign out_data  = main_pay_s[REG_W +: DATA_W];
  assign out_wreg  = main_pay_s[REG_W-1:0];
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed table-driven bench for pipe_stage_reg: three instances (skid, skid with
// 4-bit counter, no skid) share stimulus; each row checks the instance it targets.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [2:0]  in_ctrl, in_wreg;
  logic [63:0] in_data;

  logic        ir_a, ov_a, ir_b, ov_b, ir_c, ov_c;
  logic [2:0]  oc_a, ow_a, oc_b, ow_b, oc_c, ow_c;
  logic [63:0] od_a, od_b, od_c;
  logic [15:0] sc_a, sc_c;
  logic [3:0]  sc_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(3), .REG_W(3), .SKID(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_a),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_wreg(in_wreg), .out_valid(ov_a),
    .out_ready(out_ready), .out_ctrl(oc_a), .out_data(od_a), .out_wreg(ow_a),
    .stall_cnt(sc_a));

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(3), .REG_W(3), .SKID(1), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_b),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_wreg(in_wreg), .out_valid(ov_b),
    .out_ready(out_ready), .out_ctrl(oc_b), .out_data(od_b), .out_wreg(ow_b),
    .stall_cnt(sc_b));

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(3), .REG_W(3), .SKID(0), .CNT_W(16)) dut_c (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_c),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_wreg(in_wreg), .out_valid(ov_c),
    .out_ready(out_ready), .out_ctrl(oc_c), .out_data(od_c), .out_wreg(ow_c),
    .stall_cnt(sc_c));

  typedef struct {
    int          dut;   // 0 = dut_a (skid), 2 = dut_c (no skid)
    logic        rs;    // reset before applying this row
    logic        iv;
    logic [2:0]  ic;
    logic [63:0] id;
    logic        ordy;
    logic        fl;
    logic        e_ir;  // in_ready before the edge
    logic        e_ov;  // out_valid after the edge
    logic [2:0]  e_oc;
    logic [63:0] e_od;
    logic        csc;
    logic [15:0] e_sc;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t mk(int dut, logic rs, logic iv, logic [2:0] ic, logic [63:0] id,
                              logic ordy, logic fl, logic e_ir, logic e_ov, logic [2:0] e_oc,
                              logic [63:0] e_od, logic csc, logic [15:0] e_sc);
    vec_t v;
    v.dut = dut; v.rs = rs; v.iv = iv; v.ic = ic; v.id = id; v.ordy = ordy; v.fl = fl;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_oc = e_oc; v.e_od = e_od; v.csc = csc; v.e_sc = e_sc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_ctrl = 3'b111;
    in_data = 64'hDEAD; in_wreg = 3'd7; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready_a",  {63'd0, ir_a}, 64'd0);
    chk("rst_in_ready_c",  {63'd0, ir_c}, 64'd0);
    chk("rst_out_valid_a", {63'd0, ov_a}, 64'd0);
    chk("rst_out_ctrl_a",  {61'd0, oc_a}, 64'd0);
    chk("rst_out_data_a",  od_a, 64'd0);
    chk("rst_stall_a",     {48'd0, sc_a}, 64'd0);
    chk("rst_out_valid_c", {63'd0, ov_c}, 64'd0);
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic apply(input int idx, input vec_t v);
    logic        ir, ov;
    logic [2:0]  oc, ow;
    logic [63:0] od;
    logic [15:0] sc;
    in_valid = v.iv; in_ctrl = v.ic; in_data = v.id; in_wreg = v.id[2:0];
    out_ready = v.ordy; flush = v.fl;
    #1;
    ir = (v.dut == 2) ? ir_c : ir_a;
    chk($sformatf("r%0d_in_ready", idx), {63'd0, ir}, {63'd0, v.e_ir});
    @(posedge clk);
    #1;
    case (v.dut)
      2:       begin ov = ov_c; oc = oc_c; ow = ow_c; od = od_c; sc = sc_c; end
      default: begin ov = ov_a; oc = oc_a; ow = ow_a; od = od_a; sc = sc_a; end
    endcase
    chk($sformatf("r%0d_out_valid", idx), {63'd0, ov}, {63'd0, v.e_ov});
    chk($sformatf("r%0d_out_ctrl", idx), {61'd0, oc}, {61'd0, v.e_oc});
    if (v.e_ov) begin
      chk($sformatf("r%0d_out_data", idx), od, v.e_od);
      chk($sformatf("r%0d_out_wreg", idx), {61'd0, ow}, {61'd0, v.e_od[2:0]});
    end
    if (v.csc) chk($sformatf("r%0d_stall_cnt", idx), {48'd0, sc}, {48'd0, v.e_sc});
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ctrl = 3'd0;
    in_data = 64'd0; in_wreg = 3'd0; out_ready = 1'b0;

    // streaming, skid instance: out one clock after each push
    for (int k = 1; k <= 5; k++) begin
      logic [63:0] d;
      d = 64'(k);
      tab.push_back(mk(0, (k == 1), 1'b1, d[2:0], d, 1'b1, 1'b0, 1'b1, 1'b1, d[2:0], d, 1'b0, 16'd0));
    end
    tab.push_back(mk(0, 1'b0, 1'b0, 3'd0, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 64'd0, 1'b1, 16'd0));
    // backpressure: A main, B skid, C held upstream, then FIFO drain
    tab.push_back(mk(0, 1'b1, 1'b1, 3'd1, 64'hA, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 64'hA, 1'b0, 16'd0));
    tab.push_back(mk(0, 1'b0, 1'b1, 3'd2, 64'hB, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 64'hA, 1'b1, 16'd1));
    tab.push_back(mk(0, 1'b0, 1'b1, 3'd3, 64'hC, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 64'hA, 1'b1, 16'd2));
    tab.push_back(mk(0, 1'b0, 1'b1, 3'd3, 64'hC, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 64'hB, 1'b1, 16'd2));
    tab.push_back(mk(0, 1'b0, 1'b1, 3'd3, 64'hC, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 64'hC, 1'b0, 16'd0));
    tab.push_back(mk(0, 1'b0, 1'b0, 3'd0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 64'h0, 1'b1, 16'd2));
    // flush: dropped input on empty stage, then kill main+skid, then E alone
    tab.push_back(mk(0, 1'b1, 1'b1, 3'd7, 64'hD, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 64'h0, 1'b0, 16'd0));
    tab.push_back(mk(0, 1'b0, 1'b1, 3'd7, 64'hA, 1'b0, 1'b0, 1'b1, 1'b1, 3'd7, 64'hA, 1'b0, 16'd0));
    tab.push_back(mk(0, 1'b0, 1'b1, 3'd2, 64'hB, 1'b0, 1'b0, 1'b1, 1'b1, 3'd7, 64'hA, 1'b0, 16'd0));
    tab.push_back(mk(0, 1'b0, 1'b1, 3'd5, 64'hD, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 64'h0, 1'b0, 16'd0));
    tab.push_back(mk(0, 1'b0, 1'b1, 3'd1, 64'hE, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 64'hE, 1'b0, 16'd0));
    tab.push_back(mk(0, 1'b0, 1'b0, 3'd0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 64'h0, 1'b0, 16'd0));
    // no-skid instance: in_ready follows out_ready while full
    tab.push_back(mk(2, 1'b1, 1'b1, 3'd6, 64'h10, 1'b1, 1'b0, 1'b1, 1'b1, 3'd6, 64'h10, 1'b0, 16'd0));
    tab.push_back(mk(2, 1'b0, 1'b1, 3'd6, 64'h11, 1'b0, 1'b0, 1'b0, 1'b1, 3'd6, 64'h10, 1'b1, 16'd1));
    tab.push_back(mk(2, 1'b0, 1'b1, 3'd6, 64'h11, 1'b1, 1'b0, 1'b1, 1'b1, 3'd6, 64'h11, 1'b0, 16'd0));
    tab.push_back(mk(2, 1'b0, 1'b1, 3'd6, 64'h12, 1'b0, 1'b0, 1'b0, 1'b1, 3'd6, 64'h11, 1'b1, 16'd2));
    tab.push_back(mk(2, 1'b0, 1'b1, 3'd6, 64'h12, 1'b1, 1'b0, 1'b1, 1'b1, 3'd6, 64'h12, 1'b0, 16'd0));
    tab.push_back(mk(2, 1'b0, 1'b0, 3'd0, 64'h0,  1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 64'h0,  1'b1, 16'd2));

    for (int i = 0; i < tab.size(); i++) begin
      if (tab[i].rs) do_reset();
      apply(i, tab[i]);
    end

    // saturation: 4-bit counter sticks at 15, 16-bit counter keeps counting
    do_reset();
    in_valid = 1'b1; in_ctrl = 3'd4; in_data = 64'h55; in_wreg = 3'd5; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("sat_out_valid_b", {63'd0, ov_b}, 64'd1);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (k == 5 || k == 15 || k == 20)
        chk($sformatf("sat_b_k%0d", k), {60'd0, sc_b}, (k > 15) ? 64'd15 : 64'(k));
    end
    chk("sat_a_k20", {48'd0, sc_a}, 64'd20);
    @(posedge clk);
    #1;
    chk("sat_b_hold", {60'd0, sc_b}, 64'd15);
    chk("sat_a_k21", {48'd0, sc_a}, 64'd21);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_out_valid_b", {63'd0, ov_b}, 64'd0);
    chk("flush_out_ctrl_b", {61'd0, oc_b}, 64'd0);
    @(posedge clk);
    #1;
    chk("flush_keeps_stall_a", {48'd0, sc_a}, 64'd22);
    chk("flush_keeps_stall_b", {60'd0, sc_b}, 64'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
